// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: one read request, one response channel.
// The fetch unit is the master; the cache or stall-memory is the slave.
interface fetch_unit_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_stall;

  modport master (
    output imem_addr, imem_rd,
    input  imem_data, imem_done, imem_stall
  );

  modport slave (
    input  imem_addr, imem_rd,
    output imem_data, imem_done, imem_stall
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency memory and
// feeds IF/ID, absorbing memory wait, pipeline stall, redirect and halt with NOPs.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0FFF
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  input  logic                halt,
  output logic [15:0]         Instruction_out,
  output logic [15:0]         PC_plus_two_out,
  output logic                err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] buf_instr, buf_instr_n;
  logic        buf_valid, buf_valid_n;
  logic        discard, discard_n;
  logic        halt_pend, halt_pend_n;
  logic        err_n;
  logic        mem_hit;
  logic        rd_c;
  logic [15:0] instr_c;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_valid_n = buf_valid;
    discard_n   = discard;
    halt_pend_n = halt_pend;
    err_n       = 1'b0;
    mem_hit     = 1'b0;
    rd_c        = 1'b0;
    instr_c     = NOP_INSTR;

    // HALTED is terminal until reset, so a redirect there is ignored.
    if (redirect && state != HALTED) begin
      pc_n        = {redirect_pc[15:1], 1'b0};
      buf_valid_n = 1'b0;
      halt_pend_n = 1'b0;
      err_n       = redirect_pc[0];
      if (state == WAIT) begin
        // If the outstanding access returns this very cycle there is nothing left to drop.
        state_n   = imem.imem_done ? FETCH : WAIT;
        discard_n = !imem.imem_done;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (halt) begin
            state_n     = HALTED;
            buf_valid_n = 1'b0;
          end else if (buf_valid) begin
            instr_c = buf_instr;
            if (!stall) begin
              buf_valid_n = 1'b0;
              pc_n        = pc + 16'd2;
            end
          end else begin
            rd_c = 1'b1;
            if (!imem.imem_stall) begin
              if (imem.imem_done) mem_hit = 1'b1;
              else                state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem.imem_done) begin
            state_n     = (halt_pend || halt) ? HALTED : FETCH;
            halt_pend_n = 1'b0;
            discard_n   = 1'b0;
            mem_hit     = !discard && !halt_pend && !halt;
          end else if (halt) begin
            halt_pend_n = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A returned instruction is either consumed now or parked in the buffer under stall.
    if (mem_hit) begin
      instr_c = imem.imem_data;
      if (stall) begin
        buf_instr_n = imem.imem_data;
        buf_valid_n = 1'b1;
      end else begin
        pc_n = pc + 16'd2;
      end
    end
  end

  assign imem.imem_addr  = pc;
  assign imem.imem_rd    = rst ? 1'b0 : rd_c;
  assign Instruction_out = rst ? NOP_INSTR : instr_c;
  assign PC_plus_two_out = rst ? RESET_PC + 16'd2 : pc + 16'd2;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_valid <= 1'b0;
      discard   <= 1'b0;
      halt_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_instr <= buf_instr_n;
      buf_valid <= buf_valid_n;
      discard   <= discard_n;
      halt_pend <= halt_pend_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change just after a rising edge, outputs are
// compared at the following falling edge against hand-computed values.
module tb_fetch_unit;
  localparam logic [15:0] NOP = 16'h0FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, halt;
  logic [15:0] redirect_pc;
  logic [15:0] Instruction_out, PC_plus_two_out;
  logic        err;
  int          checks   = 0;
  int          failures = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (imem),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .Instruction_out (Instruction_out),
    .PC_plus_two_out (PC_plus_two_out),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sets the memory response for the coming cycle.
  task automatic mem(input logic done, input logic [15:0] data, input logic busy);
    imem.imem_done  = done;
    imem.imem_data  = data;
    imem.imem_stall = busy;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
    mem(1'b1, 16'hBEEF, 1'b0);

    // Reset, with a stray done that must be ignored
    look();
    check("rst_rd", imem.imem_rd, 16'd0);
    check("rst_instr", Instruction_out, NOP);
    check("rst_pc2", PC_plus_two_out, 16'h0002);
    next_cycle();
    look();
    check("rst_err", err, 16'd0);
    next_cycle();
    rst = 1'b0;

    // Hit stream from PC 0
    mem(1'b1, 16'h1000, 1'b0); look();
    check("hit0_rd", imem.imem_rd, 16'd1);
    check("hit0_addr", imem.imem_addr, 16'h0000);
    check("hit0_instr", Instruction_out, 16'h1000);
    check("hit0_pc2", PC_plus_two_out, 16'h0002);
    next_cycle();
    mem(1'b1, 16'h1002, 1'b0); look();
    check("hit2_addr", imem.imem_addr, 16'h0002);
    check("hit2_instr", Instruction_out, 16'h1002);
    check("hit2_pc2", PC_plus_two_out, 16'h0004);
    next_cycle();

    // Hit at PC 4 under a 2-cycle stall: held three cycles, no new request
    stall = 1'b1; mem(1'b1, 16'h1004, 1'b0); look();
    check("st0_instr", Instruction_out, 16'h1004);
    check("st0_pc2", PC_plus_two_out, 16'h0006);
    next_cycle();
    mem(1'b0, 16'h0000, 1'b0); look();
    check("st1_rd", imem.imem_rd, 16'd0);
    check("st1_instr", Instruction_out, 16'h1004);
    check("st1_pc2", PC_plus_two_out, 16'h0006);
    next_cycle();
    stall = 1'b0; look();
    check("st2_rd", imem.imem_rd, 16'd0);
    check("st2_instr", Instruction_out, 16'h1004);
    next_cycle();
    mem(1'b1, 16'h1006, 1'b0); look();
    check("hit6_addr", imem.imem_addr, 16'h0006);
    check("hit6_instr", Instruction_out, 16'h1006);
    next_cycle();

    // Miss at PC 8, done three cycles after the request
    mem(1'b0, 16'h0000, 1'b0); look();
    check("miss_req_rd", imem.imem_rd, 16'd1);
    check("miss_req_addr", imem.imem_addr, 16'h0008);
    check("miss_req_instr", Instruction_out, NOP);
    next_cycle();
    look();
    check("miss_w1_rd", imem.imem_rd, 16'd0);
    check("miss_w1_instr", Instruction_out, NOP);
    next_cycle();
    look();
    check("miss_w2_rd", imem.imem_rd, 16'd0);
    check("miss_w2_instr", Instruction_out, NOP);
    next_cycle();
    mem(1'b1, 16'h2008, 1'b0); look();
    check("miss_done_rd", imem.imem_rd, 16'd0);
    check("miss_done_instr", Instruction_out, 16'h2008);
    check("miss_done_pc2", PC_plus_two_out, 16'h000A);
    next_cycle();

    // Memory busy: request held at PC A, stall on a NOP has no effect
    stall = 1'b1; mem(1'b0, 16'h0000, 1'b1); look();
    check("busy_rd", imem.imem_rd, 16'd1);
    check("busy_addr", imem.imem_addr, 16'h000A);
    check("busy_instr", Instruction_out, NOP);
    next_cycle();
    stall = 1'b0; mem(1'b1, 16'h200A, 1'b0); look();
    check("busy_hit_instr", Instruction_out, 16'h200A);
    check("busy_hit_pc2", PC_plus_two_out, 16'h000C);
    next_cycle();

    // Redirect to 0x0040 while waiting on PC C
    mem(1'b0, 16'h0000, 1'b0); look();
    check("rw_req_addr", imem.imem_addr, 16'h000C);
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0040; look();
    check("rw_redir_rd", imem.imem_rd, 16'd0);
    check("rw_redir_instr", Instruction_out, NOP);
    next_cycle();
    redirect = 1'b0; mem(1'b1, 16'hDEAD, 1'b0); look();
    check("rw_drop_instr", Instruction_out, NOP);
    check("rw_drop_rd", imem.imem_rd, 16'd0);
    check("rw_err", err, 16'd0);
    next_cycle();
    mem(1'b1, 16'h3040, 1'b0); look();
    check("rw_new_rd", imem.imem_rd, 16'd1);
    check("rw_new_addr", imem.imem_addr, 16'h0040);
    check("rw_new_instr", Instruction_out, 16'h3040);
    check("rw_new_pc2", PC_plus_two_out, 16'h0042);
    next_cycle();

    // Odd redirect target 0x0033 from FETCH
    redirect = 1'b1; redirect_pc = 16'h0033; mem(1'b0, 16'h0000, 1'b0); look();
    check("odd_redir_instr", Instruction_out, NOP);
    check("odd_redir_rd", imem.imem_rd, 16'd0);
    next_cycle();
    redirect = 1'b0; mem(1'b1, 16'h3032, 1'b0); look();
    check("odd_err_pulse", err, 16'd1);
    check("odd_addr", imem.imem_addr, 16'h0032);
    check("odd_instr", Instruction_out, 16'h3032);
    check("odd_pc2", PC_plus_two_out, 16'h0034);
    next_cycle();
    mem(1'b0, 16'h0000, 1'b1); look();
    check("odd_err_clear", err, 16'd0);
    next_cycle();

    // PC wrap: hit at 0xFFFE gives PC_plus_two 0x0000
    redirect = 1'b1; redirect_pc = 16'hFFFE; mem(1'b0, 16'h0000, 1'b0);
    next_cycle();
    redirect = 1'b0; mem(1'b1, 16'h4FFE, 1'b0); look();
    check("wrap_addr", imem.imem_addr, 16'hFFFE);
    check("wrap_instr", Instruction_out, 16'h4FFE);
    check("wrap_pc2", PC_plus_two_out, 16'h0000);
    next_cycle();

    // Halt during WAIT: access drains, then HALTED forever
    mem(1'b0, 16'h0000, 1'b0); look();
    check("hw_req_addr", imem.imem_addr, 16'h0000);
    next_cycle();
    halt = 1'b1; look();
    check("hw_halt_instr", Instruction_out, NOP);
    next_cycle();
    halt = 1'b0; mem(1'b1, 16'h5555, 1'b0); look();
    check("hw_drain_instr", Instruction_out, NOP);
    check("hw_drain_rd", imem.imem_rd, 16'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      look();
      check("halted_rd", imem.imem_rd, 16'd0);
      check("halted_instr", Instruction_out, NOP);
      next_cycle();
    end

    // Reset leaves HALTED and fetches from RESET_PC
    rst = 1'b1; look();
    check("hrst_pc2", PC_plus_two_out, 16'h0002);
    next_cycle();
    rst = 1'b0; mem(1'b1, 16'h6000, 1'b0); look();
    check("post_rst_addr", imem.imem_addr, 16'h0000);
    check("post_rst_instr", Instruction_out, 16'h6000);
    next_cycle();

    // Halt from FETCH: no request that cycle, HALTED afterwards
    halt = 1'b1; look();
    check("hf_rd", imem.imem_rd, 16'd0);
    check("hf_instr", Instruction_out, NOP);
    next_cycle();
    halt = 1'b0; look();
    check("hf_halted_rd", imem.imem_rd, 16'd0);
    check("hf_halted_instr", Instruction_out, NOP);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
